// File: rtl/pll_pkg.sv
// Shared types and helpers for the gear-shifted bang-bang PLL.
package pll_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ACQUIRE = 2'd1,
    ST_TRACK   = 2'd2,
    ST_LOCKED  = 2'd3
  } state_e;

  typedef enum logic [1:0] {
    ERR_NONE = 2'b00,
    ERR_LAG  = 2'b01,
    ERR_LEAD = 2'b11
  } err_e;

  localparam int unsigned LG_BITS = 5;

  // Right shift that saturates to zero for any shift of 64 or more.
  function automatic logic [63:0] gain_shift(input logic [63:0] base, input logic [6:0] sh);
    gain_shift = (sh >= 7'd64) ? 64'd0 : (base >> sh);
  endfunction

endpackage

// File: rtl/pll_lock_detect.sv
// Windowed phase-error counter producing good/bad window pulses.
module pll_lock_detect
  import pll_pkg::*;
#(
  parameter int unsigned WIN_BITS = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              run,
  input  logic              clr,
  input  logic              phase_error,
  input  logic [WIN_BITS:0] err_thr,
  output logic              good_c,
  output logic              bad_c
);

  localparam int unsigned CW = WIN_BITS + 1;

  logic [WIN_BITS-1:0] win_cnt;
  logic [CW-1:0]       err_cnt;
  logic [CW-1:0]       err_sum;
  logic                last;

  // Error total including the current cycle; the window closes on the last count.
  always_comb begin
    err_sum = err_cnt;
    if (phase_error && (err_cnt != '1)) err_sum = err_cnt + CW'(1);
    last   = run && !clr && (win_cnt == '1);
    good_c = last && (err_sum <= err_thr);
    bad_c  = last && (err_sum > err_thr);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      win_cnt <= '0;
      err_cnt <= '0;
    end else if (clr || last) begin
      win_cnt <= '0;
      err_cnt <= '0;
    end else if (run) begin
      win_cnt <= win_cnt + WIN_BITS'(1);
      err_cnt <= err_sum;
    end
  end

endmodule

// File: rtl/pll_gearshift.sv
// Bang-bang NCO PLL with saturating frequency integrator and gear-shifting acquisition FSM.
module pll_gearshift
  import pll_pkg::*;
#(
  parameter int unsigned           PHASE_BITS          = 32,
  parameter bit                    OPT_TRACK_FREQUENCY = 1'b1,
  parameter logic [PHASE_BITS-1:0] INITIAL_PHASE_STEP  = '0,
  parameter int unsigned           WIN_BITS            = 8,
  parameter int unsigned           LOCK_WINDOWS        = 4,
  parameter int unsigned           LOSS_WINDOWS        = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  enable,
  input  logic                  ref_in,
  input  logic                  load_freq,
  input  logic [PHASE_BITS-2:0] freq,
  input  logic [LG_BITS-1:0]    lg_acq,
  input  logic [LG_BITS-1:0]    lg_trk,
  input  logic [WIN_BITS:0]     err_thr,
  output logic [PHASE_BITS-1:0] phase,
  output logic [1:0]            error,
  output logic                  locked,
  output logic [1:0]            state
);

  localparam int unsigned MSB      = PHASE_BITS - 1;
  localparam int unsigned RUN_MAX  = (LOCK_WINDOWS > LOSS_WINDOWS) ? LOCK_WINDOWS : LOSS_WINDOWS;
  localparam int unsigned RUN_BITS = $clog2(RUN_MAX + 1);
  localparam logic [PHASE_BITS-1:0] FMAX = {1'b0, {(PHASE_BITS-1){1'b1}}};

  state_e                state_q, state_d;
  logic [RUN_BITS-1:0]   good_run, good_d, bad_run, bad_d;
  logic [PHASE_BITS-1:0] freq_step, fstep_next, phase_next;
  logic [PHASE_BITS-1:0] phase_corr, freq_corr;
  logic [PHASE_BITS:0]   fsum;
  logic [LG_BITS-1:0]    lg;
  logic                  agreed, msb, phase_error, lead, run, clr;
  logic                  good_c, bad_c;

  assign state = state_q;

  always_comb begin
    msb         = phase[MSB];
    phase_error = msb ^ ref_in;
    lead        = agreed ? (!msb && ref_in) : (msb && !ref_in);
    run         = enable && (state_q != ST_IDLE);
    clr         = !enable || (run && load_freq);
    lg          = (state_q == ST_ACQUIRE) ? lg_acq : lg_trk;
  end

  // NCO step and saturating integrator update.
  always_comb begin
    phase_next = phase + freq_step;
    if (phase_error) phase_next = lead ? (phase_next - phase_corr) : (phase_next + phase_corr);
    fsum       = {1'b0, freq_step} + {1'b0, freq_corr};
    fstep_next = freq_step;
    if (load_freq) begin
      fstep_next = {1'b0, freq};
    end else if (run && OPT_TRACK_FREQUENCY && phase_error) begin
      if (lead) fstep_next = (freq_step >= freq_corr) ? (freq_step - freq_corr) : '0;
      else      fstep_next = (fsum > {1'b0, FMAX}) ? FMAX : fsum[PHASE_BITS-1:0];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      phase      <= '0;
      freq_step  <= INITIAL_PHASE_STEP;
      agreed     <= 1'b0;
      error      <= ERR_NONE;
      phase_corr <= '0;
      freq_corr  <= '0;
    end else begin
      phase_corr <= PHASE_BITS'(gain_shift(64'd1 << MSB, 7'(lg)));
      freq_corr  <= PHASE_BITS'(gain_shift(64'd1 << (PHASE_BITS - 3), 7'({lg, 1'b0})));
      freq_step  <= fstep_next;
      error      <= ERR_NONE;
      if (run) begin
        phase <= phase_next;
        if (msb == ref_in) agreed <= msb;
        if (phase_error) error <= lead ? ERR_LEAD : ERR_LAG;
      end
    end
  end

  pll_lock_detect #(.WIN_BITS(WIN_BITS)) u_lock (
    .clk         (clk),
    .rst         (rst),
    .run         (run),
    .clr         (clr),
    .phase_error (phase_error),
    .err_thr     (err_thr),
    .good_c      (good_c),
    .bad_c       (bad_c)
  );

  // Acquisition FSM; run counters restart whenever the state changes.
  always_comb begin
    state_d = state_q;
    good_d  = good_run;
    bad_d   = bad_run;
    if (!enable) begin
      state_d = ST_IDLE;
    end else if (state_q == ST_IDLE) begin
      state_d = ST_ACQUIRE;
    end else if (load_freq) begin
      state_d = ST_ACQUIRE;
    end else begin
      unique case (state_q)
        ST_ACQUIRE: if (good_c) state_d = ST_TRACK;
        ST_TRACK: begin
          if (good_c) begin
            good_d = good_run + RUN_BITS'(1);
            bad_d  = '0;
            if (good_d == RUN_BITS'(LOCK_WINDOWS)) state_d = ST_LOCKED;
          end else if (bad_c) begin
            bad_d  = bad_run + RUN_BITS'(1);
            good_d = '0;
            if (bad_d == RUN_BITS'(LOSS_WINDOWS)) state_d = ST_ACQUIRE;
          end
        end
        ST_LOCKED: if (bad_c) state_d = ST_TRACK;
        default: ;
      endcase
    end
    if (state_d != state_q) begin
      good_d = '0;
      bad_d  = '0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      good_run <= '0;
      bad_run  <= '0;
      locked   <= 1'b0;
    end else begin
      state_q  <= state_d;
      good_run <= good_d;
      bad_run  <= bad_d;
      locked   <= (state_d == ST_LOCKED);
    end
  end

endmodule

// File: tb/tb_pll_gearshift.sv
// Randomised and directed bench for pll_gearshift against a behavioural loop model.
module tb_pll_gearshift;

  logic        clk = 1'b0;
  logic        rst, enable, ref_in, load_freq;
  logic [14:0] freq;
  logic [4:0]  lg_acq, lg_trk;
  logic [6:0]  err_thr;
  logic [15:0] phase;
  logic [1:0]  error;
  logic        locked;
  logic [1:0]  state;

  int vectors = 0;
  int miscompares = 0;

  pll_gearshift #(
    .PHASE_BITS(16), .OPT_TRACK_FREQUENCY(1'b1), .INITIAL_PHASE_STEP(16'h0400),
    .WIN_BITS(6), .LOCK_WINDOWS(4), .LOSS_WINDOWS(2)
  ) dut (
    .clk(clk), .rst(rst), .enable(enable), .ref_in(ref_in), .load_freq(load_freq),
    .freq(freq), .lg_acq(lg_acq), .lg_trk(lg_trk), .err_thr(err_thr),
    .phase(phase), .error(error), .locked(locked), .state(state)
  );

  always #5 clk = ~clk;

  // Behavioural model: plain integer arithmetic over phase, step, window and run counts.
  int m_phase, m_fstep, m_pcorr, m_fcorr, m_err, m_st, m_win, m_errs, m_gr, m_br;
  bit m_agreed, m_locked;
  int t_msb, t_lg, t_nst, t_e;
  bit t_pe, t_lead, t_run, t_good, t_bad, t_clr;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_phase = 0; m_fstep = 'h400; m_pcorr = 0; m_fcorr = 0; m_err = 0; m_st = 0;
      m_win = 0; m_errs = 0; m_gr = 0; m_br = 0; m_agreed = 0; m_locked = 0;
    end else begin
      t_run  = enable && (m_st != 0);
      t_msb  = (m_phase >> 15) & 1;
      t_pe   = (t_msb != int'(ref_in));
      t_lead = m_agreed ? (t_msb == 0 && ref_in) : (t_msb == 1 && !ref_in);
      t_lg   = (m_st == 1) ? int'(lg_acq) : int'(lg_trk);
      m_err  = (t_run && t_pe) ? (t_lead ? 3 : 1) : 0;
      if (t_run) begin
        m_phase = (m_phase + m_fstep + (t_pe ? (t_lead ? -m_pcorr : m_pcorr) : 0)) & 'hFFFF;
        if (t_msb == int'(ref_in)) m_agreed = (t_msb == 1);
      end
      if (load_freq) m_fstep = int'(freq);
      else if (t_run && t_pe) begin
        if (t_lead) m_fstep = (m_fstep >= m_fcorr) ? m_fstep - m_fcorr : 0;
        else        m_fstep = (m_fstep + m_fcorr > 32767) ? 32767 : m_fstep + m_fcorr;
      end
      m_pcorr = 32768 >> t_lg;
      m_fcorr = (2 * t_lg >= 16) ? 0 : (8192 >> (2 * t_lg));
      t_good = 0; t_bad = 0;
      t_clr  = !enable || (load_freq && m_st != 0);
      if (t_clr) begin
        m_win = 0; m_errs = 0;
      end else if (t_run) begin
        t_e = m_errs + int'(t_pe);
        if (m_win == 63) begin
          t_good = (t_e <= int'(err_thr)); t_bad = !t_good; m_win = 0; m_errs = 0;
        end else begin
          m_win++; m_errs = t_e;
        end
      end
      t_nst = m_st;
      if (!enable) t_nst = 0;
      else if (m_st == 0 || load_freq) t_nst = 1;
      else if (m_st == 1) begin
        if (t_good) t_nst = 2;
      end else if (m_st == 2) begin
        if (t_good) begin m_gr++; m_br = 0; if (m_gr == 4) t_nst = 3; end
        else if (t_bad) begin m_br++; m_gr = 0; if (m_br == 2) t_nst = 1; end
      end else if (t_bad) t_nst = 2;
      if (t_nst != m_st) begin m_gr = 0; m_br = 0; end
      m_st = t_nst;
      m_locked = (t_nst == 3);
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  int ref_mode;   // 0 fixed, 1 matched, 2 anti-phase, 3 random
  bit ref_fix;

  // One clock: drive ref, step the edge, compare every output with the model.
  task automatic cyc(input int n);
    for (int i = 0; i < n; i++) begin
      case (ref_mode)
        0:       ref_in = ref_fix;
        1:       ref_in = m_phase[15];
        2:       ref_in = !m_phase[15];
        default: ref_in = 1'($urandom_range(0, 1));
      endcase
      @(posedge clk);
      #1;
      if (!rst) begin
        chk("phase", 32'(phase), 32'(m_phase));
        chk("error", 32'(error), 32'(m_err));
        chk("state", 32'(state), 32'(m_st));
        chk("locked", 32'(locked), 32'(m_locked));
        chk("freq_step", 32'(dut.freq_step), 32'(m_fstep));
      end
      @(negedge clk);
    end
  endtask

  int n, t_trk, hold_ph;

  initial begin
    rst = 1; enable = 0; ref_in = 0; load_freq = 0; freq = '0;
    lg_acq = 5'd4; lg_trk = 5'd5; err_thr = 7'd8; ref_mode = 1; ref_fix = 0;
    repeat (2) @(negedge clk);
    rst = 0;
    chk("rst_phase", 32'(phase), 32'h0);
    chk("rst_state", 32'(state), 32'h0);
    chk("rst_fstep", 32'(dut.freq_step), 32'h0400);

    // Matched reference: ACQUIRE->TRACK after one window, LOCKED after four more.
    enable = 1; n = 0; t_trk = 0;
    while (!locked && n < 400) begin
      cyc(1); n++;
      if (state == 2'd2 && t_trk == 0) t_trk = n;
    end
    chk("trk_edge", 32'(t_trk), 32'd65);
    chk("lock_edge", 32'(n), 32'd321);

    // Anti-phase reference: one bad window to TRACK, two more to ACQUIRE.
    ref_mode = 2; n = 0; t_trk = 0;
    while (state != 2'd1 && n < 300) begin
      cyc(1); n++;
      if (state == 2'd2 && t_trk == 0) t_trk = n;
    end
    chk("loss_trk", 32'(t_trk), 32'd64);
    chk("loss_acq", 32'(n), 32'd192);
    chk("loss_locked", 32'(locked), 32'd0);

    // Relock, then load_freq in LOCKED forces ACQUIRE with fresh counters.
    ref_mode = 1; n = 0;
    while (!locked && n < 400) begin cyc(1); n++; end
    chk("relock_edge", 32'(n), 32'd320);
    load_freq = 1; freq = 15'h1234;
    cyc(1);
    load_freq = 0;
    chk("load_fstep", 32'(dut.freq_step), 32'h1234);
    chk("load_state", 32'(state), 32'd1);
    n = 0;
    while (state != 2'd2 && n < 100) begin cyc(1); n++; end
    chk("load_clr_win", 32'(n), 32'd64);

    // Disable: IDLE on the next edge, phase frozen.
    hold_ph = m_phase;
    enable = 0;
    cyc(6);
    chk("idle_state", 32'(state), 32'd0);
    chk("idle_hold", 32'(phase), 32'(hold_ph));

    // Asynchronous reset in mid-run.
    enable = 1;
    cyc(40);
    #2 rst = 1;
    #1;
    chk("arst_phase", 32'(phase), 32'h0);
    chk("arst_state", 32'(state), 32'h0);
    chk("arst_locked", 32'(locked), 32'h0);
    chk("arst_fstep", 32'(dut.freq_step), 32'h0400);
    @(negedge clk);
    rst = 0;

    // Upper clamp: persistent lag at lg=0 from phase 0x4400 with agreed=0.
    lg_acq = 5'd0; lg_trk = 5'd0; ref_mode = 1;
    cyc(17);
    load_freq = 1; freq = 15'h7FFE;
    cyc(1);
    load_freq = 0; ref_mode = 0; ref_fix = 1;
    cyc(10);
    chk("sat_hi_fstep", 32'(dut.freq_step), 32'h7FFF);
    chk("sat_hi_phase", 32'(phase), 32'h43F5);
    chk("sat_hi_state", 32'(state), 32'd1);

    // Lower clamp region and general randomised operation, checked by the model.
    load_freq = 1; freq = 15'd1; lg_acq = 5'd3; lg_trk = 5'd4; ref_mode = 3;
    cyc(1);
    load_freq = 0;
    cyc(60);
    for (int i = 0; i < 2500; i++) begin
      if (i % 150 == 0) ref_mode = int'($urandom_range(1, 3));
      if (i % 97 == 0) begin
        lg_acq  = 5'($urandom_range(0, 10));
        lg_trk  = 5'($urandom_range(2, 31));
        err_thr = 7'($urandom_range(0, 70));
      end
      enable    = ($urandom_range(0, 99) != 0);
      load_freq = ($urandom_range(0, 63) == 0);
      case ($urandom_range(0, 2))
        0:       freq = 15'($urandom_range(0, 3));
        1:       freq = 15'(32767 - $urandom_range(0, 3));
        default: freq = 15'($urandom);
      endcase
      cyc(1);
    end
    load_freq = 0;

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/pll_gearshift.md
# pll_gearshift

Parametrised successor to the single-gain bang-bang phase accumulator PLL. It tracks a 1-bit comparator input with an NCO phase accumulator and adds a saturating frequency integrator. Loop gain is gear-shifted by a four-state acquisition FSM: wide gain while acquiring, narrow gain while tracking. A windowed error-count lock detector drives the FSM and produces a `locked` flag for the SWIPT control path.

## Interface
- `PHASE_BITS`, 32: accumulator width; MSB = PHASE_BITS-1.
- `OPT_TRACK_FREQUENCY`, 1: enables the frequency integrator.
- `INITIAL_PHASE_STEP`, 0: reset value of `freq_step`.
- `WIN_BITS`, 8: lock window length = 2^WIN_BITS enabled cycles.
- `LOCK_WINDOWS`, 4: consecutive good windows required TRACK->LOCKED.
- `LOSS_WINDOWS`, 2: consecutive bad windows required TRACK->ACQUIRE.
- `clk` in 1: single clock.
- `rst` in 1: asynchronous, active-high reset.
- `enable` in 1: loop run enable (SWIPT alive).
- `ref_in` in 1: comparator input.
- `load_freq` in 1: load `freq` into `freq_step`.
- `freq` in PHASE_BITS-1: new step, zero-extended.
- `lg_acq` in 5: log2 gain shift used in ACQUIRE.
- `lg_trk` in 5: log2 gain shift used in TRACK/LOCKED.
- `err_thr` in WIN_BITS+1: max phase errors for a window to count as good.
- `phase` out PHASE_BITS: accumulator value.
- `error` out 2: 00 no error, 11 lead, 01 lag.
- `locked` out 1: high only in LOCKED.
- `state` out 2: IDLE=0, ACQUIRE=1, TRACK=2, LOCKED=3.

## Operation
- phase_error = `phase[MSB]` != `ref_in`.
- agreed register: set when `ref_in` and `phase[MSB]` are both 1; cleared when both are 0; updates only while enabled.
- lead: if agreed, !`phase[MSB]` && `ref_in`; else `phase[MSB]` && !`ref_in`.
- Active shift lg = `lg_acq` in ACQUIRE, otherwise `lg_trk`.
- Corrections are registered each cycle:
  - phase_corr = 2^MSB >> lg.
  - freq_corr = 2^(MSB-2) >> (2*lg); a shift ≥ PHASE_BITS gives 0.
- While in ACQUIRE/TRACK/LOCKED, `phase` updates each cycle by `freq_step` plus an error-dependent correction:
  - no error: += `freq_step`.
  - lead: += `freq_step` - phase_corr.
  - lag: += `freq_step` + phase_corr.
  - All arithmetic is mod 2^PHASE_BITS; wrap-around is intended.
- `freq_step` (PHASE_BITS wide, MSB always 0):
  - `load_freq` has priority over everything else.
  - Otherwise, when running with OPT_TRACK_FREQUENCY set and phase_error: lead subtracts freq_corr, lag adds it.
  - Saturates to [0, 2^MSB-1]; it never wraps.
- In IDLE, `phase`, `freq_step` and the agreed register hold; `error`=00.
- Lock detector:
  - Window counter and error counter (saturating, WIN_BITS+1 bits) advance only in ACQUIRE/TRACK/LOCKED.
  - At the last cycle of a window the window is good when errors (including that cycle) ≤ `err_thr`. Both counters then clear.
- FSM:
  - IDLE -> ACQUIRE when `enable`.
  - Any state -> IDLE when !`enable`.
  - ACQUIRE -> TRACK on one good window.
  - TRACK -> LOCKED after LOCK_WINDOWS consecutive good windows.
  - TRACK -> ACQUIRE after LOSS_WINDOWS consecutive bad windows.
  - LOCKED -> TRACK on any bad window.
  - `load_freq` while running forces ACQUIRE.
- Good/bad run counters clear on every state change.
- Entering IDLE or forcing ACQUIRE clears the detector counters.

## Timing
- Reset values:
  - `phase`=0, `freq_step`=INITIAL_PHASE_STEP, agreed=0.
  - `error`=00, `locked`=0, `state`=IDLE.
  - Corrections=0; all counters=0.
- `error` is registered from the current-cycle comparison, so it lags by 1 cycle.
- A gear change takes effect on corrections 1 cycle after the `state` change.
- `freq` loads on the edge where `load_freq` is sampled and is visible next cycle. A simultaneous phase_error correction is discarded.
- `locked` rises on the same edge `state` becomes LOCKED, and falls on the same edge it leaves.
- `enable` deasserting mid-window: the next edge gives IDLE and clears the counters; `phase` freezes at its current value.
- Asserting `rst` mid-operation clears everything immediately.

## Structure
- `pll_pkg`: state encoding, error codes (ERR_NONE/LEAD/LAG), gain-shift helper function.
- Sub-module `pll_lock_detect`: window counter, error counter, good/bad window pulse outputs. Parameter WIN_BITS; inputs `run`, `clr`, `phase_error`, `err_thr`.
- The top level holds the NCO, the frequency integrator and the FSM.

## Test plan
1. Reset: assert `rst` mid-run with PHASE_BITS=16, INITIAL_PHASE_STEP=0x0400 -> `phase`=0, `freq_step`=0x0400, `state`=0, `locked`=0 asynchronously.
2. Free-run: `enable`=1, ref square wave matching a step of 0x0400, `err_thr`=8, WIN_BITS=6 -> `state` goes 1, then 2, then 3 after 5 windows; `locked`=1.
3. Pull-in: ref period corresponds to step 0x0600, `freq_step` starts at 0x0400, `lg_acq`=2, `lg_trk`=5 -> `freq_step` converges within ±0x20 of 0x0600 and lock is reached.
4. Saturation: `freq_step`=0x7FFE with a persistent lag and lg=0 -> it clamps at 0x7FFF. A `freq_step` of 1 with persistent lead -> it clamps at 0.
5. Loss: from LOCKED, stop toggling ref -> TRACK after 1 window, ACQUIRE after 2 more, `locked`=0.
6. `load_freq`=1 in LOCKED with `freq`=0x1234 -> next cycle `freq_step`=0x1234, `state`=ACQUIRE, counters cleared. Deasserting `enable` -> IDLE with `phase` held.
